mem_stage: RTL and testbench

- Memory-access stage directly downstream of the execute stage.
- Pops entries from the exe2mem FIFO and issues load/store requests to the data-memory port with a req/ack handshake.
- Aligns and sign/zero-extends load data, then pushes results into an internal mem2wbk FIFO read by writeback.
- Drives the MEM_DEST_RM/MEM_RES_RM bypass used by execute.

---
 rtl/mem_stage_if.sv | 55 +++++
 rtl/mem_stage.sv | 197 +++++++++++++++++++
 tb/tb_mem_stage.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// mem_stage_if: signal bundle for the memory stage. It groups the exe2mem
// FIFO head, the data-memory req/ack port and the mem2wbk FIFO head.
// The master modport is the memory stage; the slave modport is everything
// around it (execute, data memory, writeback).
interface mem_stage_if;
   // exe2mem FIFO head
   logic [31:0] RES_RE;
   logic [31:0] MEM_DATA_RE;
   logic [5:0]  DEST_RE;
   logic [1:0]  MEM_SIZE_RE;
   logic        WB_RE;
   logic        MEM_SIGN_EXTEND_RE;
   logic        MEM_LOAD_RE;
   logic        MEM_STORE_RE;
   logic        EXCEPTION_RE;
   logic [31:0] PC_EXE2MEM_RE;
   logic        EXE2MEM_EMPTY_SE;
   logic        EXE2MEM_POP_SM;
   // data-memory port
   logic        DMEM_REQ_SM;
   logic [31:0] DMEM_ADR_SM;
   logic [31:0] DMEM_WDATA_SM;
   logic        DMEM_WE_SM;
   logic [3:0]  DMEM_BE_SM;
   logic        DMEM_ACK_SM;
   logic [31:0] DMEM_RDATA_SM;
   // mem2wbk FIFO head
   logic [31:0] MEM_RES_RM;
   logic [5:0]  MEM_DEST_RM;
   logic        WB_RM;
   logic        EXCEPTION_RM;
   logic [31:0] PC_MEM2WBK_RM;
   logic        MEM2WBK_EMPTY_SM;
   logic        MEM2WBK_POP_SW;

   modport master (
      input  RES_RE, MEM_DATA_RE, DEST_RE, MEM_SIZE_RE, WB_RE,
             MEM_SIGN_EXTEND_RE, MEM_LOAD_RE, MEM_STORE_RE, EXCEPTION_RE,
             PC_EXE2MEM_RE, EXE2MEM_EMPTY_SE,
             DMEM_ACK_SM, DMEM_RDATA_SM, MEM2WBK_POP_SW,
      output EXE2MEM_POP_SM, DMEM_REQ_SM, DMEM_ADR_SM, DMEM_WDATA_SM,
             DMEM_WE_SM, DMEM_BE_SM, MEM_RES_RM, MEM_DEST_RM, WB_RM,
             EXCEPTION_RM, PC_MEM2WBK_RM, MEM2WBK_EMPTY_SM
   );

   modport slave (
      output RES_RE, MEM_DATA_RE, DEST_RE, MEM_SIZE_RE, WB_RE,
             MEM_SIGN_EXTEND_RE, MEM_LOAD_RE, MEM_STORE_RE, EXCEPTION_RE,
             PC_EXE2MEM_RE, EXE2MEM_EMPTY_SE,
             DMEM_ACK_SM, DMEM_RDATA_SM, MEM2WBK_POP_SW,
      input  EXE2MEM_POP_SM, DMEM_REQ_SM, DMEM_ADR_SM, DMEM_WDATA_SM,
             DMEM_WE_SM, DMEM_BE_SM, MEM_RES_RM, MEM_DEST_RM, WB_RM,
             EXCEPTION_RM, PC_MEM2WBK_RM, MEM2WBK_EMPTY_SM
   );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between execute and writeback.
// Pops exe2mem entries, runs load/store requests over a req/ack data-memory
// port, aligns/extends load data and pushes results into the internal
// mem2wbk FIFO whose head doubles as the execute bypass.
// Optional macro MEM_PERF_CNT_EN adds load/store/stall performance counters.
module mem_stage #(
   parameter int WBK_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   mem_stage_if.master bus
`ifdef MEM_PERF_CNT_EN
   ,
   output logic [31:0] PERF_LOADS_SM,
   output logic [31:0] PERF_STORES_SM,
   output logic [31:0] PERF_STALL_SM
`endif
);

   localparam int AW = $clog2(WBK_DEPTH);
   localparam int CW = $clog2(WBK_DEPTH + 1);

   typedef enum logic {IDLE, ACCESS} state_t;

   typedef struct packed {
      logic [31:0] res;
      logic [5:0]  dest;
      logic        wb;
      logic        exc;
      logic [31:0] pc;
   } wbk_ent_t;

   state_t          state, state_nxt;
   logic            req, pop_exe, push;
   logic            entry, is_mem, fifo_full, pop_wbk, space;
   logic [1:0]      lane_adr;
   logic [31:0]     lane, load_data, wdata;
   logic [3:0]      be;
   wbk_ent_t        push_ent, head_ent, last_ent;
   wbk_ent_t        mem [WBK_DEPTH];
   logic [AW-1:0]   rd_ptr, wr_ptr;
   logic [CW-1:0]   count;

   // Request qualification: an exception entry never touches memory, it
   // just flows through like an ALU result.
   always_comb begin
      entry     = !bus.EXE2MEM_EMPTY_SE;
      is_mem    = (bus.MEM_LOAD_RE || bus.MEM_STORE_RE) && !bus.EXCEPTION_RE;
      fifo_full = (count == CW'(WBK_DEPTH));
      pop_wbk   = bus.MEM2WBK_POP_SW && (count != '0);
      // A pop in the same cycle frees a slot for a push into a full FIFO.
      space     = !fifo_full || pop_wbk;
   end

   // Next-state and handshake control. REQ is combinational from IDLE so a
   // same-cycle ACK completes the access with single-cycle latency; space is
   // checked only at issue, and nothing else pushes while in ACCESS, so the
   // slot stays reserved until the ACK.
   always_comb begin
      state_nxt = state;
      req       = 1'b0;
      pop_exe   = 1'b0;
      push      = 1'b0;
      if (!reset) begin
         case (state)
            IDLE: begin
               if (entry && space) begin
                  if (!is_mem) begin
                     push    = 1'b1;
                     pop_exe = 1'b1;
                  end else begin
                     req = 1'b1;
                     if (bus.DMEM_ACK_SM) begin
                        push    = 1'b1;
                        pop_exe = 1'b1;
                     end else begin
                        state_nxt = ACCESS;
                     end
                  end
               end
            end
            ACCESS: begin
               req = 1'b1;
               if (bus.DMEM_ACK_SM) begin
                  push      = 1'b1;
                  pop_exe   = 1'b1;
                  state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // FSM state register; reset abandons any outstanding request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Byte enables and lane-replicated store data from the low address bits.
   always_comb begin
      lane_adr = bus.RES_RE[1:0];
      case (bus.MEM_SIZE_RE)
         2'b10: begin
            be    = 4'b0001 << lane_adr;
            wdata = {4{bus.MEM_DATA_RE[7:0]}};
         end
         2'b01: begin
            be    = 4'b0011 << lane_adr;
            wdata = {2{bus.MEM_DATA_RE[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wdata = bus.MEM_DATA_RE;
         end
      endcase
   end

   // Load alignment: shift the addressed lane down to bit 0, then extend.
   always_comb begin
      lane = bus.DMEM_RDATA_SM >> {lane_adr, 3'b000};
      case (bus.MEM_SIZE_RE)
         2'b10:   load_data = bus.MEM_SIGN_EXTEND_RE ? {{24{lane[7]}}, lane[7:0]}
                                                     : {24'h0, lane[7:0]};
         2'b01:   load_data = bus.MEM_SIGN_EXTEND_RE ? {{16{lane[15]}}, lane[15:0]}
                                                     : {16'h0, lane[15:0]};
         default: load_data = bus.DMEM_RDATA_SM;
      endcase
   end

   // Result entry: loads carry memory data, everything else the ALU result.
   always_comb begin
      push_ent.res  = (bus.MEM_LOAD_RE && !bus.EXCEPTION_RE) ? load_data : bus.RES_RE;
      push_ent.dest = bus.DEST_RE;
      push_ent.wb   = bus.WB_RE && !bus.EXCEPTION_RE;
      push_ent.exc  = bus.EXCEPTION_RE;
      push_ent.pc   = bus.PC_EXE2MEM_RE;
   end

   // mem2wbk storage, pointers and occupancy; pointers wrap on the
   // power-of-two depth.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < WBK_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_ent;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop_wbk) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop_wbk);
      end
   end

   // Copy of the most recently popped head so the bypass holds it when empty.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)        last_ent <= '0;
      else if (pop_wbk) last_ent <= mem[rd_ptr];
   end

   assign head_ent = (count == '0) ? last_ent : mem[rd_ptr];

   assign bus.EXE2MEM_POP_SM   = pop_exe;
   assign bus.DMEM_REQ_SM      = req;
   assign bus.DMEM_ADR_SM      = {bus.RES_RE[31:2], 2'b00};
   assign bus.DMEM_WDATA_SM    = wdata;
   assign bus.DMEM_WE_SM       = req && bus.MEM_STORE_RE;
   assign bus.DMEM_BE_SM       = be;
   assign bus.MEM_RES_RM       = head_ent.res;
   assign bus.MEM_DEST_RM      = head_ent.dest;
   assign bus.WB_RM            = head_ent.wb;
   assign bus.EXCEPTION_RM     = head_ent.exc;
   assign bus.PC_MEM2WBK_RM    = head_ent.pc;
   assign bus.MEM2WBK_EMPTY_SM = (count == '0);

`ifdef MEM_PERF_CNT_EN
   // Counters: ACKed loads/stores, plus cycles lost waiting on memory or
   // blocked on a full mem2wbk FIFO.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         PERF_LOADS_SM  <= '0;
         PERF_STORES_SM <= '0;
         PERF_STALL_SM  <= '0;
      end else begin
         if (req && bus.DMEM_ACK_SM && bus.MEM_LOAD_RE)  PERF_LOADS_SM  <= PERF_LOADS_SM + 32'd1;
         if (req && bus.DMEM_ACK_SM && bus.MEM_STORE_RE) PERF_STORES_SM <= PERF_STORES_SM + 32'd1;
         if ((state == ACCESS && !bus.DMEM_ACK_SM) || (state == IDLE && entry && fifo_full))
            PERF_STALL_SM <= PERF_STALL_SM + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage with a queue-level reference
// model of the exe2mem feed and the mem2wbk FIFO, checked every cycle.
`timescale 1ns/1ps
module tb_mem_stage;
   localparam int DEPTH = 2;

   typedef struct {
      logic [31:0] res, data, pc;
      logic [5:0]  dest;
      logic [1:0]  size;
      logic        wb, sext, ld, st, exc;
   } instr_t;

   typedef struct {
      logic [31:0] res;
      logic [5:0]  dest;
      logic        wb, exc;
      logic [31:0] pc;
   } wbk_t;

   logic   clk = 1'b0;
   logic   reset = 1'b1;
   int     n_cmp = 0;
   int     n_bad = 0;
   instr_t stim [128];
   int     n_stim = 0;   // written by the stimulus process only
   int     head = 0;     // written by the model process only
   wbk_t   q[$];
   wbk_t   last_pop;

   mem_stage_if bus();

`ifdef MEM_PERF_CNT_EN
   logic [31:0] perf_loads, perf_stores, perf_stall;
   mem_stage #(.WBK_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .PERF_LOADS_SM(perf_loads), .PERF_STORES_SM(perf_stores), .PERF_STALL_SM(perf_stall));
`else
   mem_stage #(.WBK_DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif

   initial forever #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Spec-level result of one exe2mem entry given the memory read data.
   function automatic wbk_t expect_ent(input instr_t i, input logic [31:0] rd);
      wbk_t        e;
      logic [31:0] sh;
      sh    = rd >> (8 * i.res[1:0]);
      e.res = i.res;
      if (i.ld && !i.exc) begin
         if (i.size == 2'b10)      e.res = i.sext ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
         else if (i.size == 2'b01) e.res = i.sext ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
         else                      e.res = rd;
      end
      e.dest = i.dest;
      e.wb   = i.exc ? 1'b0 : i.wb;
      e.exc  = i.exc;
      e.pc   = i.pc;
      return e;
   endfunction

   // Present the exe2mem head to the DUT.
   task automatic drive();
      instr_t c;
      if (head < n_stim) begin
         c = stim[head];
         bus.EXE2MEM_EMPTY_SE = 1'b0;
      end else begin
         c = '{default: '0};
         bus.EXE2MEM_EMPTY_SE = 1'b1;
      end
      bus.RES_RE             = c.res;
      bus.MEM_DATA_RE        = c.data;
      bus.DEST_RE            = c.dest;
      bus.MEM_SIZE_RE        = c.size;
      bus.WB_RE              = c.wb;
      bus.MEM_SIGN_EXTEND_RE = c.sext;
      bus.MEM_LOAD_RE        = c.ld;
      bus.MEM_STORE_RE       = c.st;
      bus.EXCEPTION_RE       = c.exc;
      bus.PC_EXE2MEM_RE      = c.pc;
   endtask

   // Reference model and per-cycle compare: checks at the falling edge,
   // advances the queues at the rising edge.
   initial begin : model
      instr_t      cur;
      wbk_t        e, hd;
      logic        has, ldst, spc, do_push, do_pop, do_wpop;
      logic [3:0]  be;
      logic [31:0] wd;
      last_pop = '{default: '0};
      drive();
      forever begin
         @(negedge clk);
         do_push = 1'b0; do_pop = 1'b0; do_wpop = 1'b0;
         if (reset) begin
            q.delete();
            last_pop = '{default: '0};
            head = n_stim;
            drive();
            chk("rst_req", bus.DMEM_REQ_SM, 0);
            chk("rst_pop", bus.EXE2MEM_POP_SM, 0);
            chk("rst_we", bus.DMEM_WE_SM, 0);
         end else begin
            has  = head < n_stim;
            cur  = has ? stim[head] : '{default: '0};
            ldst = has && (cur.ld || cur.st) && !cur.exc;
            do_wpop = bus.MEM2WBK_POP_SW && (q.size() > 0);
            spc  = (q.size() - int'(do_wpop)) < DEPTH;
            chk("req_legal", bus.DMEM_REQ_SM && !ldst, 0);
            chk("pop_legal", bus.EXE2MEM_POP_SM && !(has && spc), 0);
            if (has && spc && !ldst) chk("alu_pop", bus.EXE2MEM_POP_SM, 1);
            if (ldst && spc) begin
               chk("req_on", bus.DMEM_REQ_SM, 1);
               chk("pop_eq_ack", bus.EXE2MEM_POP_SM, bus.DMEM_ACK_SM);
               be = (cur.size == 2'b10) ? 4'(1 << cur.res[1:0]) :
                    (cur.size == 2'b01) ? 4'(3 << cur.res[1:0]) : 4'hF;
               wd = (cur.size == 2'b10) ? {4{cur.data[7:0]}} :
                    (cur.size == 2'b01) ? {2{cur.data[15:0]}} : cur.data;
               chk("adr", bus.DMEM_ADR_SM, {cur.res[31:2], 2'b00});
               chk("be", bus.DMEM_BE_SM, be);
               chk("wdata", bus.DMEM_WDATA_SM, wd);
               chk("we", bus.DMEM_WE_SM, cur.st);
            end
            if (bus.EXE2MEM_POP_SM && has) begin
               e = expect_ent(cur, bus.DMEM_RDATA_SM);
               do_push = 1'b1;
               do_pop  = 1'b1;
            end
         end
         hd = (q.size() > 0) ? q[0] : last_pop;
         chk("empty", bus.MEM2WBK_EMPTY_SM, q.size() == 0);
         chk("head_res", bus.MEM_RES_RM, hd.res);
         chk("head_dest", bus.MEM_DEST_RM, hd.dest);
         chk("head_wb", bus.WB_RM, hd.wb);
         chk("head_exc", bus.EXCEPTION_RM, hd.exc);
         chk("head_pc", bus.PC_MEM2WBK_RM, hd.pc);
         @(posedge clk);
         if (do_wpop) last_pop = q.pop_front();
         if (do_push) q.push_back(e);
         if (do_pop)  head++;
         #2 drive();
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic [31:0] res, input logic [31:0] data, input logic [5:0] dest,
                      input logic [1:0] size, input logic wb, input logic sext,
                      input logic ld, input logic st, input logic exc);
      instr_t i;
      i.res = res; i.data = data; i.dest = dest; i.size = size; i.wb = wb;
      i.sext = sext; i.ld = ld; i.st = st; i.exc = exc; i.pc = 32'h400 + 32'(n_stim * 4);
      stim[n_stim] = i;
      n_stim++;
   endtask

   task automatic drain();
      cyc();
      bus.MEM2WBK_POP_SW = 1'b1;
      repeat (4) cyc();
      bus.MEM2WBK_POP_SW = 1'b0;
   endtask

   initial begin : stimulus
      bus.DMEM_ACK_SM    = 1'b0;
      bus.DMEM_RDATA_SM  = '0;
      bus.MEM2WBK_POP_SW = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_empty", bus.MEM2WBK_EMPTY_SM, 1);
      chk("rst_res", bus.MEM_RES_RM, 0);
      chk("rst_pc", bus.PC_MEM2WBK_RM, 0);
      cyc();
      reset = 1'b0;

      // Store byte, ACK two cycles late: REQ held three cycles.
      cyc();
      add(32'h1003, 32'hAB, 6'd1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk("sb_req0", bus.DMEM_REQ_SM, 1);
      chk("sb_adr", bus.DMEM_ADR_SM, 32'h1000);
      chk("sb_be", bus.DMEM_BE_SM, 4'b1000);
      chk("sb_wdata", bus.DMEM_WDATA_SM, 32'hABABABAB);
      cyc();
      @(negedge clk);
      chk("sb_req1", bus.DMEM_REQ_SM, 1);
      chk("sb_nopop1", bus.EXE2MEM_POP_SM, 0);
      cyc();
      bus.DMEM_ACK_SM = 1'b1; bus.DMEM_RDATA_SM = 32'hDEADBEEF;
      @(negedge clk);
      chk("sb_req2", bus.DMEM_REQ_SM, 1);
      chk("sb_pop2", bus.EXE2MEM_POP_SM, 1);
      cyc();
      bus.DMEM_ACK_SM = 1'b0;
      @(negedge clk);
      chk("sb_req_off", bus.DMEM_REQ_SM, 0);
      chk("sb_res", bus.MEM_RES_RM, 32'h1003);
      chk("sb_wb", bus.WB_RM, 0);
      drain();

      // Load half at lane 2, signed then unsigned, immediate ACK.
      for (int s = 1; s >= 0; s--) begin
         cyc();
         add(32'h2002, 32'h0, 6'd2, 2'b01, 1'b1, s[0], 1'b1, 1'b0, 1'b0);
         bus.DMEM_ACK_SM = 1'b1; bus.DMEM_RDATA_SM = 32'h80011234;
         @(negedge clk);
         chk("lh_be", bus.DMEM_BE_SM, 4'b1100);
         chk("lh_pop", bus.EXE2MEM_POP_SM, 1);
         cyc();
         bus.DMEM_ACK_SM = 1'b0;
         @(negedge clk);
         chk("lh_res", bus.MEM_RES_RM, s ? 32'hFFFF8001 : 32'h00008001);
         drain();
      end

      // ALU entry: no memory request, result visible next cycle.
      cyc();
      add(32'h55, 32'h0, 6'd5, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("alu_req", bus.DMEM_REQ_SM, 0);
      cyc();
      @(negedge clk);
      chk("alu_dest", bus.MEM_DEST_RM, 6'd5);
      chk("alu_res", bus.MEM_RES_RM, 32'h55);
      chk("alu_wb", bus.WB_RM, 1);
      drain();
      @(negedge clk);
      chk("hold_res", bus.MEM_RES_RM, 32'h55);

      // Exception load: no request, WB forced off.
      cyc();
      add(32'h77, 32'h0, 6'd7, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      chk("exc_req", bus.DMEM_REQ_SM, 0);
      cyc();
      @(negedge clk);
      chk("exc_wb", bus.WB_RM, 0);
      chk("exc_flag", bus.EXCEPTION_RM, 1);
      drain();

      // Backpressure: three ALU entries into a depth-2 FIFO.
      cyc();
      for (int k = 0; k < 3; k++)
         add(32'h100 + 32'(k), 32'h0, 6'(10 + k), 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) begin @(negedge clk); cyc(); end
      @(negedge clk);
      chk("bp_stall", bus.EXE2MEM_POP_SM, 0);
      chk("bp_empty", bus.MEM2WBK_EMPTY_SM, 0);
      chk("bp_head", bus.MEM_RES_RM, 32'h100);
      cyc();
      bus.MEM2WBK_POP_SW = 1'b1;
      @(negedge clk);
      chk("bp_third", bus.EXE2MEM_POP_SM, 1);
      cyc();
      bus.MEM2WBK_POP_SW = 1'b0;
      @(negedge clk);
      chk("bp_head2", bus.MEM_RES_RM, 32'h101);
      drain();

      // Reset while a request is pending; a late ACK causes no push.
      cyc();
      add(32'h300, 32'h0, 6'd3, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc();
      add(32'h3004, 32'h0, 6'd4, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk("rr_req", bus.DMEM_REQ_SM, 1);
      cyc();
      reset = 1'b1;
      @(negedge clk);
      chk("rr_req_drop", bus.DMEM_REQ_SM, 0);
      chk("rr_empty", bus.MEM2WBK_EMPTY_SM, 1);
      cyc();
      reset = 1'b0;
      cyc();
      bus.DMEM_ACK_SM = 1'b1;
      @(negedge clk);
      chk("rr_late_ack", bus.EXE2MEM_POP_SM, 0);
      cyc();
      bus.DMEM_ACK_SM = 1'b0;
      @(negedge clk);
      chk("rr_no_push", bus.MEM2WBK_EMPTY_SM, 1);

      // Mixed stream of sizes and lanes with irregular ACK and writeback pops.
      cyc();
      for (int k = 0; k < 12; k++) begin
         logic [1:0] sz, a;
         sz = 2'(k % 3);
         a  = (sz == 2'b10) ? 2'(k % 4) : (sz == 2'b01) ? 2'((k % 2) * 2) : 2'b00;
         add({20'h4, 10'(k), a}, 32'hC3A5_7E81 + 32'(k), 6'(20 + k), sz, k[1], k[2],
             (k % 4) != 3, (k % 4) == 3, 1'b0);
      end
      for (int c = 0; c < 120 && head < n_stim; c++) begin
         cyc();
         bus.DMEM_ACK_SM    = 1'($urandom_range(0, 1));
         bus.DMEM_RDATA_SM  = $urandom;
         bus.MEM2WBK_POP_SW = 1'($urandom_range(0, 1));
      end
      cyc();
      bus.DMEM_ACK_SM = 1'b0;
      chk("stream_done", head, n_stim);
      drain();
      @(negedge clk);
      chk("final_empty", bus.MEM2WBK_EMPTY_SM, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
